// File: rtl/riscv_dmem_responder_if.sv
// Request/response bus between the CPU MEM stage (master) and the data-memory
// responder (slave): valid/ready request channel plus valid/ready response channel.
interface riscv_dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Word-indexed data memory with configurable response latency, one transaction in flight.
// Optional RISCV_DMEM_ERR_CHECK_EN flags misaligned / out-of-range accesses via resp_err.
module riscv_dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input logic                   clock,
   input logic                   reset_n,
   riscv_dmem_responder_if.slave bus
);

   localparam int CW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     cnt;
   logic              accept;
   logic              go_resp;

   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;

   logic              cur_we;
   logic [31:0]       cur_addr;
   logic [31:0]       cur_wdata;
   logic [3:0]        cur_wstrb;
   logic [31:0]       word_sel;
   logic [IDX_W-1:0]  idx;
   logic              cur_err;

   logic [31:0]       rdata_q;
   logic              err_q;
   logic [31:0]       mem [DEPTH];

   // With zero latency the access completes on the acceptance edge, so the
   // live request fields are used instead of the captured copies.
   assign cur_we    = (state == IDLE) ? bus.req_we    : we_q;
   assign cur_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
   assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
   assign cur_wstrb = (state == IDLE) ? bus.req_wstrb : wstrb_q;
   assign word_sel  = cur_addr >> 2;

`ifdef RISCV_DMEM_ERR_CHECK_EN
   assign cur_err = (cur_addr[1:0] != 2'b00) || (word_sel >= 32'(DEPTH));
   assign idx     = IDX_W'(word_sel);
`else
   assign cur_err = 1'b0;
   assign idx     = IDX_W'(word_sel % 32'(DEPTH));
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      accept         = 1'b0;
      go_resp        = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  state_nxt = RESP;
                  go_resp   = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == CW'(1)) begin
               state_nxt = RESP;
               go_resp   = 1'b1;
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept)              cnt <= CW'(LATENCY);
         else if (state == WAIT)  cnt <= cnt - CW'(1);
         if (go_resp) begin
            err_q   <= cur_err;
            rdata_q <= (cur_we || cur_err) ? 32'h0 : mem[idx];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         we_q    <= bus.req_we;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         wstrb_q <= bus.req_wstrb;
      end
   end

   // Storage is not reset; reset_n gates the commit so a store caught by reset is dropped.
   always_ff @(posedge clock) begin
      if (go_resp && reset_n && cur_we && !cur_err) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_wstrb[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
         end
      end
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

endmodule
